// File: rtl/weight_preload_pkg.sv
// Shared definitions for the weight preload path: FSM states, sizing helper
// and the kernel row decode also used by the BRAM write controller.
package weight_preload_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } preload_state_t;

    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // Any code that is not one-hot decodes to a single row.
    function automatic logic [2:0] kernel_rows(input logic [4:0] kernel_size);
        case (kernel_size)
            5'b00001: return 3'd1;
            5'b00010: return 3'd2;
            5'b00100: return 3'd3;
            5'b01000: return 3'd4;
            5'b10000: return 3'd5;
            default:  return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/preload_word_fifo.sv
// Small synchronous FIFO of packed weight words with a combinational head
// output; a push into a full FIFO is accepted only alongside a pop.
module preload_word_fifo
    import weight_preload_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic [clogb2(DEPTH-1):0]    cnt,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = clogb2(DEPTH - 1);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; the head is masked to zero while empty, so
    // stale contents are never observable and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/weight_preload_packer.sv
// Packs AXI-Stream weight beats into 5*MAC_NUM-bit words and queues them for
// the BRAM write controller until the layer's word count has been delivered.
module weight_preload_packer
    import weight_preload_pkg::*;
#(
    parameter int  MAC_NUM                 = 256,
    parameter int  AXIS_DATA_WIDTH         = 64,
    parameter int  AXIS_PRELOAD_FIFO_DEPTH = 4,
    localparam int BEATS                   = 5 * MAC_NUM / AXIS_DATA_WIDTH,
    localparam int bit_num                 = clogb2(AXIS_PRELOAD_FIFO_DEPTH - 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    input  logic                         preload_start,
    input  logic [4:0]                   kernel_size,
    input  logic [11:0]                  output_channel_size,
    input  logic                         layer_finish,
    input  logic                         read_axis_preload_fifo,
    output logic [5*MAC_NUM-1:0]         weight_from_preload,
    output logic [bit_num:0]             axis_fifo_cnt,
    output logic                         wait_input_from_preload,
    output logic                         preload_busy,
    output logic                         preload_done
);

    localparam int WORD_W = 5 * MAC_NUM;
    localparam int BCW    = (BEATS > 1) ? clogb2(BEATS - 1) : 1;

    preload_state_t   state, state_next;
    logic [BCW-1:0]   beat_cnt;
    logic [12:0]      word_cnt;
    logic [12:0]      layer_words;
    logic [12:0]      layer_words_in;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] beat_word;
    logic [WORD_W-1:0] fifo_din;
    logic             hold_last;
    logic             start_ok;
    logic             accept;
    logic             word_last_beat;
    logic             fifo_space;
    logic             fifo_push;
    logic             push_is_last;
    logic             fifo_full;
    logic             fifo_empty;
    logic [bit_num:0] fifo_cnt;

    assign layer_words_in = 13'({3'b0, output_channel_size} * {12'b0, kernel_rows(kernel_size)});
    assign start_ok       = preload_start && (layer_words_in != 13'd0);
    assign accept         = (state == FILL) && s_axis_tvalid;
    assign word_last_beat = accept && ((beat_cnt == BCW'(BEATS - 1)) || s_axis_tlast);
    assign fifo_space     = !fifo_full || read_axis_preload_fifo;

    // Upper slices stay zero because the assembly register is cleared after
    // every completed word, which gives the zero padding on an early tlast.
    always_comb begin
        beat_word = asm_word;
        beat_word[int'(beat_cnt)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        fifo_push    = 1'b0;
        fifo_din     = asm_word;
        push_is_last = 1'b0;
        if (layer_finish) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start_ok) state_next = FILL;
                FILL: begin
                    if (word_last_beat) begin
                        fifo_din     = beat_word;
                        push_is_last = s_axis_tlast || (word_cnt + 13'd1 == layer_words);
                        if (fifo_space) begin
                            fifo_push  = 1'b1;
                            state_next = push_is_last ? DONE : FILL;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end
                HOLD: begin
                    push_is_last = hold_last || (word_cnt + 13'd1 == layer_words);
                    if (fifo_space) begin
                        fifo_push  = 1'b1;
                        state_next = push_is_last ? DONE : FILL;
                    end
                end
                DONE: if (fifo_cnt == '0) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || layer_finish) begin
            beat_cnt    <= '0;
            word_cnt    <= '0;
            asm_word    <= '0;
            hold_last   <= 1'b0;
            layer_words <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        beat_cnt    <= '0;
                        word_cnt    <= '0;
                        asm_word    <= '0;
                        hold_last   <= 1'b0;
                        layer_words <= layer_words_in;
                    end
                end
                FILL: begin
                    if (word_last_beat) begin
                        beat_cnt <= '0;
                        if (fifo_push) begin
                            asm_word <= '0;
                            word_cnt <= word_cnt + 13'd1;
                        end else begin
                            asm_word  <= beat_word;
                            hold_last <= s_axis_tlast;
                        end
                    end else if (accept) begin
                        asm_word <= beat_word;
                        beat_cnt <= beat_cnt + BCW'(1);
                    end
                end
                HOLD: begin
                    if (fifo_push) begin
                        asm_word  <= '0;
                        word_cnt  <= word_cnt + 13'd1;
                        hold_last <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // An abort flushes the queue through the FIFO's own reset.
    preload_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (AXIS_PRELOAD_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst || layer_finish),
        .push  (fifo_push),
        .pop   (read_axis_preload_fifo),
        .din   (fifo_din),
        .dout  (weight_from_preload),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign axis_fifo_cnt           = fifo_cnt;
    assign wait_input_from_preload = !fifo_empty;
    assign s_axis_tready           = (state == FILL);
    assign preload_busy            = (state != IDLE);
    assign preload_done            = fifo_push && push_is_last;

endmodule

// File: tb/tb_weight_preload_packer.sv
// Directed bench for weight_preload_packer with 40-bit words (5 beats of 8 bits)
// and a 4-deep preload FIFO.
module tb_weight_preload_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        preload_start;
    logic [4:0]  kernel_size;
    logic [11:0] output_channel_size;
    logic        layer_finish;
    logic        read_axis_preload_fifo;
    logic [39:0] weight_from_preload;
    logic [2:0]  axis_fifo_cnt;
    logic        wait_input_from_preload;
    logic        preload_busy;
    logic        preload_done;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    weight_preload_packer #(
        .MAC_NUM                 (8),
        .AXIS_DATA_WIDTH         (8),
        .AXIS_PRELOAD_FIFO_DEPTH (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tlast            (s_axis_tlast),
        .s_axis_tready           (s_axis_tready),
        .preload_start           (preload_start),
        .kernel_size             (kernel_size),
        .output_channel_size     (output_channel_size),
        .layer_finish            (layer_finish),
        .read_axis_preload_fifo  (read_axis_preload_fifo),
        .weight_from_preload     (weight_from_preload),
        .axis_fifo_cnt           (axis_fifo_cnt),
        .wait_input_from_preload (wait_input_from_preload),
        .preload_busy            (preload_busy),
        .preload_done            (preload_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (preload_done === 1'b1) done_count++;

    initial begin
        #200000;
        $display("FAIL watchdog_timeout simulation did not finish");
        $fatal(1);
    end

    // Word n of a stream whose beat k (1-based) carries the value k.
    function automatic logic [39:0] exp_word(input int n);
        logic [39:0] w;
        for (int k = 0; k < 5; k++) w[k*8 +: 8] = 8'(5 * n + 1 + k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_layer(input logic [4:0] ks, input logic [11:0] ocs);
        tick();
        kernel_size = ks;
        output_channel_size = ocs;
        preload_start = 1'b1;
        tick();
        preload_start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        int n;
        tick();
        s_axis_tdata = d;
        s_axis_tlast = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept got tready=%b expected 1 (data %h)", s_axis_tready, d);
        end
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic pop_word(input logic [39:0] expected);
        tick();
        read_axis_preload_fifo = 1'b1;
        @(negedge clk);
        checks++;
        if (weight_from_preload !== expected || wait_input_from_preload !== 1'b1) begin
            errors++;
            $display("FAIL pop_head got %h wait=%b expected %h wait=1", weight_from_preload, wait_input_from_preload, expected);
        end
        tick();
        read_axis_preload_fifo = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0 || axis_fifo_cnt !== 3'd0 || wait_input_from_preload !== 1'b0 ||
            preload_busy !== 1'b0 || preload_done !== 1'b0 || weight_from_preload !== 40'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b cnt=%0d wait=%b busy=%b done=%b head=%h expected all zero",
                     s_axis_tready, axis_fifo_cnt, wait_input_from_preload, preload_busy, preload_done, weight_from_preload);
        end
    endtask

    task automatic test_basic_packing();
        int d0;
        d0 = done_count;
        start_layer(5'b00001, 12'd2);
        @(negedge clk);
        checks++;
        if (preload_busy !== 1'b1 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL basic_fill got busy=%b rdy=%b expected 1 1", preload_busy, s_axis_tready);
        end
        for (int i = 1; i <= 5; i++) send_beat(8'(i), 1'b0);
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd1 || weight_from_preload !== 40'h0504030201 || wait_input_from_preload !== 1'b1) begin
            errors++;
            $display("FAIL basic_word0 got cnt=%0d head=%h wait=%b expected 1 0504030201 1",
                     axis_fifo_cnt, weight_from_preload, wait_input_from_preload);
        end
        for (int i = 6; i <= 10; i++) send_beat(8'(i), 1'b0);
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd2 || (done_count - d0) !== 1 || s_axis_tready !== 1'b0 || preload_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done got cnt=%0d dones=%0d rdy=%b busy=%b expected 2 1 0 1",
                     axis_fifo_cnt, done_count - d0, s_axis_tready, preload_busy);
        end
        start_layer(5'b00001, 12'd2);
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0 || preload_busy !== 1'b1 || axis_fifo_cnt !== 3'd2) begin
            errors++;
            $display("FAIL start_in_done got rdy=%b busy=%b cnt=%0d expected 0 1 2", s_axis_tready, preload_busy, axis_fifo_cnt);
        end
        pop_word(40'h0504030201);
        pop_word(40'h0a09080706);
        tick();
        @(negedge clk);
        checks++;
        if (preload_busy !== 1'b0 || axis_fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL basic_drain got busy=%b cnt=%0d expected 0 0", preload_busy, axis_fifo_cnt);
        end
    endtask

    task automatic test_backpressure();
        int d0;
        d0 = done_count;
        start_layer(5'b00100, 12'd2);
        for (int i = 1; i <= 20; i++) send_beat(8'(i), 1'b0);
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd4 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL bp_four_words got cnt=%0d rdy=%b expected 4 1", axis_fifo_cnt, s_axis_tready);
        end
        for (int i = 21; i <= 25; i++) send_beat(8'(i), 1'b0);
        tick();
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd4 || s_axis_tready !== 1'b0 || preload_busy !== 1'b1 || (done_count - d0) !== 0) begin
            errors++;
            $display("FAIL bp_hold got cnt=%0d rdy=%b busy=%b dones=%0d expected 4 0 1 0",
                     axis_fifo_cnt, s_axis_tready, preload_busy, done_count - d0);
        end
        pop_word(exp_word(0));
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd4 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume got cnt=%0d rdy=%b expected 4 1", axis_fifo_cnt, s_axis_tready);
        end
    endtask

    task automatic test_full_with_pop();
        int d0;
        d0 = done_count;
        for (int i = 26; i <= 29; i++) send_beat(8'(i), 1'b0);
        tick();
        s_axis_tdata = 8'd30;
        s_axis_tvalid = 1'b1;
        read_axis_preload_fifo = 1'b1;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b1 || preload_done !== 1'b1 || weight_from_preload !== exp_word(1)) begin
            errors++;
            $display("FAIL fullpop_cycle got rdy=%b done=%b head=%h expected 1 1 %h",
                     s_axis_tready, preload_done, weight_from_preload, exp_word(1));
        end
        tick();
        s_axis_tvalid = 1'b0;
        read_axis_preload_fifo = 1'b0;
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd4 || s_axis_tready !== 1'b0 || preload_busy !== 1'b1 || (done_count - d0) !== 1) begin
            errors++;
            $display("FAIL fullpop_after got cnt=%0d rdy=%b busy=%b dones=%0d expected 4 0 1 1",
                     axis_fifo_cnt, s_axis_tready, preload_busy, done_count - d0);
        end
        for (int n = 2; n <= 5; n++) pop_word(exp_word(n));
        tick();
        @(negedge clk);
        checks++;
        if (preload_busy !== 1'b0 || axis_fifo_cnt !== 3'd0) begin
            errors++;
            $display("FAIL fullpop_drain got busy=%b cnt=%0d expected 0 0", preload_busy, axis_fifo_cnt);
        end
    endtask

    task automatic test_early_tlast();
        int d0;
        d0 = done_count;
        // Non one-hot kernel code counts as one row: 3 words expected.
        start_layer(5'b00011, 12'd3);
        for (int i = 1; i <= 6; i++) send_beat(8'(i), 1'b0);
        send_beat(8'd7, 1'b1);
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd2 || s_axis_tready !== 1'b0 || preload_busy !== 1'b1 || (done_count - d0) !== 1) begin
            errors++;
            $display("FAIL tlast_done got cnt=%0d rdy=%b busy=%b dones=%0d expected 2 0 1 1",
                     axis_fifo_cnt, s_axis_tready, preload_busy, done_count - d0);
        end
        pop_word(40'h0504030201);
        pop_word(40'h0000000706);
        tick();
        @(negedge clk);
        checks++;
        if (preload_busy !== 1'b0) begin
            errors++;
            $display("FAIL tlast_drain got busy=%b expected 0", preload_busy);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_count;
        start_layer(5'b00001, 12'd4);
        for (int i = 1; i <= 12; i++) send_beat(8'(i), 1'b0);
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd2 || wait_input_from_preload !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre got cnt=%0d wait=%b expected 2 1", axis_fifo_cnt, wait_input_from_preload);
        end
        tick();
        layer_finish = 1'b1;
        tick();
        layer_finish = 1'b0;
        @(negedge clk);
        checks++;
        if (preload_busy !== 1'b0 || axis_fifo_cnt !== 3'd0 || wait_input_from_preload !== 1'b0 ||
            s_axis_tready !== 1'b0 || weight_from_preload !== 40'h0 || (done_count - d0) !== 0) begin
            errors++;
            $display("FAIL abort_post got busy=%b cnt=%0d wait=%b rdy=%b head=%h dones=%0d expected 0 0 0 0 0 0",
                     preload_busy, axis_fifo_cnt, wait_input_from_preload, s_axis_tready, weight_from_preload, done_count - d0);
        end
        start_layer(5'b00001, 12'd1);
        for (int i = 0; i < 5; i++) send_beat(8'(8'h11 + i), 1'b0);
        @(negedge clk);
        checks++;
        if (weight_from_preload !== 40'h1514131211 || axis_fifo_cnt !== 3'd1 || (done_count - d0) !== 1) begin
            errors++;
            $display("FAIL abort_restart got head=%h cnt=%0d dones=%0d expected 1514131211 1 1",
                     weight_from_preload, axis_fifo_cnt, done_count - d0);
        end
        pop_word(40'h1514131211);
        tick();
    endtask

    task automatic test_reset_corners();
        start_layer(5'b00001, 12'd2);
        for (int i = 1; i <= 3; i++) send_beat(8'(i), 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 1'b0 || axis_fifo_cnt !== 3'd0 || wait_input_from_preload !== 1'b0 ||
            preload_busy !== 1'b0 || preload_done !== 1'b0 || weight_from_preload !== 40'h0) begin
            errors++;
            $display("FAIL midfill_reset got rdy=%b cnt=%0d wait=%b busy=%b done=%b head=%h expected all zero",
                     s_axis_tready, axis_fifo_cnt, wait_input_from_preload, preload_busy, preload_done, weight_from_preload);
        end
        tick();
        read_axis_preload_fifo = 1'b1;
        tick();
        read_axis_preload_fifo = 1'b0;
        @(negedge clk);
        checks++;
        if (axis_fifo_cnt !== 3'd0 || wait_input_from_preload !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty got cnt=%0d wait=%b expected 0 0", axis_fifo_cnt, wait_input_from_preload);
        end
        start_layer(5'b00001, 12'd0);
        @(negedge clk);
        checks++;
        if (preload_busy !== 1'b0 || s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL zero_words_start got busy=%b rdy=%b expected 0 0", preload_busy, s_axis_tready);
        end
        start_layer(5'b00001, 12'd1);
        for (int i = 0; i < 5; i++) send_beat(8'(8'h21 + i), 1'b0);
        @(negedge clk);
        checks++;
        if (weight_from_preload !== 40'h2524232221 || axis_fifo_cnt !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_word got head=%h cnt=%0d expected 2524232221 1", weight_from_preload, axis_fifo_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        preload_start = 1'b0;
        kernel_size = 5'b00001;
        output_channel_size = '0;
        layer_finish = 1'b0;
        read_axis_preload_fifo = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        test_reset();
        test_basic_packing();
        test_backpressure();
        test_full_with_pop();
        test_early_tlast();
        test_abort();
        test_reset_corners();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_preload_packer.md
Name: weight_preload_packer

Overview:
- Producer end of the weight preload path.
- Accepts the layer's weight stream from an AXI-Stream slave port and packs narrow beats into 5*MAC_NUM-bit weight words.
- Buffers packed words in a small preload FIFO and presents them to the BRAM write controller using that controller's handshake: data available, head word, pop strobe and occupancy count.
- Stops accepting data once the layer's word count (kernel rows × output channels) has been delivered.

Parameters:
- MAC_NUM, 256: MAC lanes; one word is 5*MAC_NUM bits.
- AXIS_DATA_WIDTH, 64: s_axis_tdata width; 5*MAC_NUM must be an integer multiple of it.
- AXIS_PRELOAD_FIFO_DEPTH, 4: packed-word FIFO depth, power of two, ≥2.
- BEATS, 5*MAC_NUM/AXIS_DATA_WIDTH: derived; beats per word.
- bit_num, clogb2(AXIS_PRELOAD_FIFO_DEPTH-1): derived; count port is bit_num+1 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  AXIS_DATA_WIDTH  weight beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of the layer stream
- s_axis_tready  out  1  beat accepted when tvalid&tready
- preload_start  in  1  one-cycle pulse; begin a layer
- kernel_size  in  5  one-hot rows: 00001=1 … 10000=5; other codes=1
- output_channel_size  in  12  output channels
- layer_finish  in  1  abort/flush; highest priority after rst
- read_axis_preload_fifo  in  1  pop strobe from the BRAM controller
- weight_from_preload  out  5*MAC_NUM  FIFO head word
- axis_fifo_cnt  out  bit_num+1  FIFO occupancy
- wait_input_from_preload  out  1  FIFO non-empty
- preload_busy  out  1  state != IDLE
- preload_done  out  1  one-cycle pulse when the last word is pushed

Behaviour:
- Reset (rst=1 at a clk edge), all registered outputs and state cleared:
  - s_axis_tready=0, axis_fifo_cnt=0, wait_input_from_preload=0, preload_busy=0, preload_done=0, weight_from_preload=0.
  - FIFO pointers, beat_cnt and word_cnt = 0; state=IDLE.
- layer_words = output_channel_size × rows, 13 bits.
- States: IDLE, FILL, HOLD, DONE.
- IDLE:
  - preload_start with layer_words≠0 → FILL; clears beat_cnt, word_cnt and the assembly register.
  - preload_start with layer_words=0 is ignored.
- FILL:
  - s_axis_tready=1.
  - Each accepted beat is written into assembly slice [beat_cnt*W +: W]; beat 0 goes to the LSBs.
  - beat_cnt increments on each accepted beat.
- Word complete: accepted beat with beat_cnt=BEATS-1, or any accepted beat with tlast=1.
  - Unfilled upper slices of the assembly register are zero.
  - If the FIFO has space (not full, or full with a pop in the same cycle), the word is pushed that cycle and state stays in FILL.
  - Otherwise → HOLD.
  - word_cnt increments on push; beat_cnt resets to 0.
- HOLD:
  - s_axis_tready=0.
  - The word is pushed in the first cycle with space, then → FILL.
- Push with word_cnt+1 = layer_words → DONE; preload_done pulses in the push cycle.
- Early tlast: tlast before layer_words is reached is treated as the last word. The word is pushed, then → DONE.
- Surplus beats: beats after the final word are not accepted (tready=0).
- DONE:
  - s_axis_tready=0.
  - Returns to IDLE when the FIFO drains (cnt=0) or on layer_finish.
- FIFO:
  - Synchronous; weight_from_preload is the combinational head word, valid in the cycle read_axis_preload_fifo is high. The consumer samples it in that cycle.
  - The pop takes effect at the clock edge.
  - Pop when empty is ignored.
  - Simultaneous push+pop leaves count unchanged.
  - Count never exceeds DEPTH.
  - Pointers wrap modulo DEPTH.
- layer_finish in any state:
  - → IDLE next cycle; FIFO flushed (cnt=0).
  - Partial word discarded; no preload_done.
- preload_start outside IDLE is ignored.
- Latency: the final beat of a word is visible at the head and raises wait_input_from_preload one cycle after acceptance, when the FIFO was empty.

Decomposition:
- Shared package weight_preload_pkg:
  - clogb2 function.
  - State localparams IDLE=0, FILL=1, HOLD=2, DONE=3.
  - kernel_rows(kernel_size) function, shared with the BRAM write controller's word-count logic.
- One sub-module preload_word_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports push/pop/din/dout/cnt/full/empty.
  - Same clock and reset.

Test Plan (MAC_NUM=8, AXIS_DATA_WIDTH=8 → 40-bit words, 5 beats; DEPTH=4):
- Basic packing:
  - Stimulus: kernel_size=00001, output_channel_size=2; send beats 01..0A, consumer idle.
  - Required: after beat 5, cnt=1 and head=0x0504030201; after beat 10, cnt=2 and preload_done pulses once; state DONE, tready=0.
- Backpressure:
  - Stimulus: kernel_size=00100, output_channel_size=2 (6 words); never pop.
  - Required: 4 words pushed; 5th word completes → HOLD, tready=0, cnt=4. Pop once → word pushed the next cycle, cnt stays 4, FILL resumes.
- Full with simultaneous pop:
  - Stimulus: cnt=4 and read strobe in the same cycle as a word-completing beat.
  - Required: push accepted, cnt stays 4, no HOLD entry.
- Early tlast:
  - Stimulus: layer_words=3; send 7 beats with tlast on beat 7.
  - Required: second word = 0x0000000706 zero-padded; preload_done pulses; 2 words total; DONE.
- Abort:
  - Stimulus: layer_finish mid-word with cnt=2.
  - Required: next cycle state=IDLE, cnt=0, wait_input_from_preload=0, no preload_done.
- Reset and corners:
  - Stimulus: rst mid-FILL; pop on empty; preload_start with output_channel_size=0.
  - Required: all outputs at reset values; pop has no effect; start ignored, busy stays 0.
